dcache_inv_snooper: RTL and testbench

- Generates the invalidation side of the d$ interface: drives dcache_inv_valid / dcache_inv_block_addr into the local dcache.
- Snoops block write traffic from the remote core's dmem write channel on the shared bus.
- Queues snooped block addresses in a small deduplicating FIFO and issues at most one invalidation pulse per allowed slot.
- Sits between the bus/mem controller and DCACHE for multicore bring-up; provides backpressure to the remote writer and a drained indication for halt.

---
 rtl/dcache_inv_snooper.sv | 104 ++++++++++
 tb/tb_dcache_inv_snooper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_inv_snooper.sv
// rtl/dcache_inv_snooper.sv - snoops remote block writes and issues local dcache invalidations
// Deduplicating FIFO of snooped block addresses, drained at most one pulse per INV_GAP cycles.
module dcache_inv_snooper #(
  parameter int BLOCK_ADDR_WIDTH = 13,
  parameter int DEPTH            = 4,
  parameter int INV_GAP          = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        DUT_error,
  input  logic                        snoop_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] snoop_block_addr,
  output logic                        snoop_slow_down,
  output logic                        dcache_inv_valid,
  output logic [BLOCK_ADDR_WIDTH-1:0] dcache_inv_block_addr,
  input  logic                        halt_req,
  output logic                        snooper_flushed
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int GW = (INV_GAP > 1) ? $clog2(INV_GAP) : 1;

  typedef logic [BLOCK_ADDR_WIDTH-1:0] block_addr_t;

  block_addr_t      entry_addr [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [GW-1:0]    gap_cnt;

  logic [IW-1:0]    head_idx;
  logic [IW-1:0]    tail_idx;
  logic [PW-1:0]    count;
  logic [PW-1:0]    count_next;
  logic             full;
  logic             deq;
  logic             match;
  logic             accept;
  logic             drop;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign count    = tail - head;
  assign full     = (count == PW'(DEPTH));
  assign deq      = entry_valid[head_idx] && (gap_cnt == '0);

  // The entry leaving this cycle is excluded so a rewrite racing its pulse is re-queued.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == snoop_block_addr) &&
          !(deq && (IW'(i) == head_idx))) begin
        match = 1'b1;
      end
    end
  end

  assign accept     = snoop_valid && !match && (!full || deq);
  assign drop       = snoop_valid && !match && full && !deq;
  assign count_next = count + PW'(accept) - PW'(deq);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry_valid           <= '0;
      head                  <= '0;
      tail                  <= '0;
      gap_cnt               <= '0;
      DUT_error             <= 1'b0;
      snoop_slow_down       <= 1'b0;
      dcache_inv_valid      <= 1'b0;
      dcache_inv_block_addr <= '0;
      snooper_flushed       <= 1'b0;
    end else begin
      dcache_inv_valid <= 1'b0;
      if (deq) begin
        dcache_inv_valid      <= 1'b1;
        dcache_inv_block_addr <= entry_addr[head_idx];
        entry_valid[head_idx] <= 1'b0;
        head                  <= head + PW'(1);
        gap_cnt               <= GW'(INV_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      // On a full FIFO the tail slot is the head slot being freed; the enqueue must win.
      if (accept) begin
        entry_valid[tail_idx] <= 1'b1;
        tail                  <= tail + PW'(1);
      end
      if (drop) begin
        DUT_error <= 1'b1;
      end
      snoop_slow_down <= (count_next >= PW'(DEPTH - 1));
      snooper_flushed <= halt_req && (count_next == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      entry_addr[tail_idx] <= snoop_block_addr;
    end
  end

endmodule

// File: tb/tb_dcache_inv_snooper.sv
// tb/tb_dcache_inv_snooper.sv - directed self-checking bench for dcache_inv_snooper
// Three instances cover INV_GAP = 1, 3 and 8 with a shared clock and reset.
module tb_dcache_inv_snooper;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        sv1 = 1'b0, sv3 = 1'b0, sv8 = 1'b0;
  logic [12:0] sa1 = '0, sa3 = '0, sa8 = '0;
  logic        h1 = 1'b0, h3 = 1'b0, h8 = 1'b0;
  logic        e1, e3, e8;
  logic        sd1, sd3, sd8;
  logic        iv1, iv3, iv8;
  logic [12:0] ia1, ia3, ia8;
  logic        f1, f3, f8;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses_after_rst;

  always #5 CLK = ~CLK;

  dcache_inv_snooper #(.BLOCK_ADDR_WIDTH(13), .DEPTH(4), .INV_GAP(1)) u_g1 (
    .CLK(CLK), .RST(RST), .DUT_error(e1), .snoop_valid(sv1), .snoop_block_addr(sa1),
    .snoop_slow_down(sd1), .dcache_inv_valid(iv1), .dcache_inv_block_addr(ia1),
    .halt_req(h1), .snooper_flushed(f1));

  dcache_inv_snooper #(.BLOCK_ADDR_WIDTH(13), .DEPTH(4), .INV_GAP(3)) u_g3 (
    .CLK(CLK), .RST(RST), .DUT_error(e3), .snoop_valid(sv3), .snoop_block_addr(sa3),
    .snoop_slow_down(sd3), .dcache_inv_valid(iv3), .dcache_inv_block_addr(ia3),
    .halt_req(h3), .snooper_flushed(f3));

  dcache_inv_snooper #(.BLOCK_ADDR_WIDTH(13), .DEPTH(4), .INV_GAP(8)) u_g8 (
    .CLK(CLK), .RST(RST), .DUT_error(e8), .snoop_valid(sv8), .snoop_block_addr(sa8),
    .snoop_slow_down(sd8), .dcache_inv_valid(iv8), .dcache_inv_block_addr(ia8),
    .halt_req(h8), .snooper_flushed(f8));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_err", {e1, e3, e8}, 3'b000);
    chk("rst_sd", {sd1, sd3, sd8}, 3'b000);
    chk("rst_iv", {iv1, iv3, iv8}, 3'b000);
    chk("rst_ia", {ia1, ia3, ia8}, 39'd0);
    chk("rst_fl", {f1, f3, f8}, 3'b000);
    RST = 1'b0;
    tick();

    // single snoop, INV_GAP=1
    sv1 = 1'b1; sa1 = 13'h0A3;
    tick();
    sv1 = 1'b0;
    chk("lat_no_bypass", iv1, 1'b0);
    tick();
    chk("lat_iv", iv1, 1'b1);
    chk("lat_ia", ia1, 13'h0A3);
    tick();
    chk("lat_iv_drop", iv1, 1'b0);
    chk("lat_ia_hold", ia1, 13'h0A3);
    tick();
    chk("lat_idle", iv1, 1'b0);
    chk("lat_err", e1, 1'b0);

    // dedupe on INV_GAP=3: prime with 0x005 so 0x010 is still queued when repeated
    sv3 = 1'b1; sa3 = 13'h005;
    tick();
    sa3 = 13'h010;
    tick();
    chk("dd_p0_iv", iv3, 1'b1);
    chk("dd_p0_ia", ia3, 13'h005);
    sa3 = 13'h010;
    tick();
    chk("dd_e2", iv3, 1'b0);
    sa3 = 13'h020;
    tick();
    sv3 = 1'b0;
    chk("dd_e3", iv3, 1'b0);
    tick();
    chk("dd_p1_iv", iv3, 1'b1);
    chk("dd_p1_ia", ia3, 13'h010);
    tick();
    tick();
    chk("dd_e6", iv3, 1'b0);
    tick();
    chk("dd_p2_iv", iv3, 1'b1);
    chk("dd_p2_ia", ia3, 13'h020);
    tick();
    chk("dd_e8", iv3, 1'b0);
    tick();
    chk("dd_e9", iv3, 1'b0);
    tick();
    chk("dd_e10", iv3, 1'b0);
    chk("dd_err", e3, 1'b0);

    // gap spacing: pulses at t+1, t+4, t+7
    sv3 = 1'b1; sa3 = 13'h001;
    tick();
    sa3 = 13'h002;
    tick();
    chk("gap_p1_iv", iv3, 1'b1);
    chk("gap_p1_ia", ia3, 13'h001);
    sa3 = 13'h003;
    tick();
    sv3 = 1'b0;
    chk("gap_f2", iv3, 1'b0);
    tick();
    chk("gap_f3", iv3, 1'b0);
    tick();
    chk("gap_p2_iv", iv3, 1'b1);
    chk("gap_p2_ia", ia3, 13'h002);
    tick();
    chk("gap_f5", iv3, 1'b0);
    tick();
    chk("gap_f6", iv3, 1'b0);
    tick();
    chk("gap_p3_iv", iv3, 1'b1);
    chk("gap_p3_ia", ia3, 13'h003);

    // INV_GAP=8: fill to full, enqueue 0x1FF on the exact dequeue cycle
    sv8 = 1'b1; sa8 = 13'h100;
    tick();
    sa8 = 13'h101;
    tick();
    chk("full_p0_iv", iv8, 1'b1);
    chk("full_p0_ia", ia8, 13'h100);
    chk("full_sd_c1", sd8, 1'b0);
    sa8 = 13'h102;
    tick();
    chk("full_sd_c2", sd8, 1'b0);
    sa8 = 13'h103;
    tick();
    chk("full_sd_c3", sd8, 1'b1);
    sa8 = 13'h104;
    tick();
    sv8 = 1'b0;
    chk("full_sd_c4", sd8, 1'b1);
    repeat (4) tick();
    chk("full_hold", iv8, 1'b0);
    sv8 = 1'b1; sa8 = 13'h1FF;
    tick();
    sv8 = 1'b0;
    chk("full_deq_iv", iv8, 1'b1);
    chk("full_deq_ia", ia8, 13'h101);
    chk("full_deq_err", e8, 1'b0);
    chk("full_deq_sd", sd8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [12:0] exp_a;
      exp_a = (k == 3) ? 13'h1FF : 13'(13'h102 + k);
      repeat (7) tick();
      chk("drain_gap", iv8, 1'b0);
      tick();
      chk("drain_iv", iv8, 1'b1);
      chk("drain_ia", ia8, exp_a);
    end
    chk("drain_sd", sd8, 1'b0);
    chk("drain_err", e8, 1'b0);

    // overflow while dequeue is held
    repeat (8) tick();
    sv8 = 1'b1; sa8 = 13'h200;
    tick();
    sa8 = 13'h201;
    tick();
    sa8 = 13'h202;
    tick();
    chk("ovf_sd_c2", sd8, 1'b0);
    sa8 = 13'h203;
    tick();
    chk("ovf_sd_c3", sd8, 1'b1);
    sa8 = 13'h204;
    tick();
    chk("ovf_err_c4", e8, 1'b0);
    sa8 = 13'h205;
    tick();
    sv8 = 1'b0;
    chk("ovf_err_c5", e8, 1'b1);
    repeat (4) tick();
    chk("ovf_deq_iv", iv8, 1'b1);
    chk("ovf_deq_ia", ia8, 13'h201);
    chk("ovf_err_sticky", e8, 1'b1);

    // reset with three pending and a pulse in flight
    RST = 1'b1;
    #1;
    chk("mrst_iv", iv8, 1'b0);
    chk("mrst_ia", ia8, 13'h000);
    chk("mrst_err", e8, 1'b0);
    chk("mrst_sd", sd8, 1'b0);
    chk("mrst_fl", f8, 1'b0);
    tick();
    RST = 1'b0;
    pulses_after_rst = 0;
    repeat (40) begin
      tick();
      if (iv8 !== 1'b0) pulses_after_rst++;
    end
    chk("mrst_no_pulse", pulses_after_rst, 0);

    // halt drain on INV_GAP=3 with two pending
    sv3 = 1'b1; sa3 = 13'h02F;
    tick();
    h3 = 1'b1; sa3 = 13'h030;
    tick();
    chk("fl_k1", f3, 1'b0);
    sa3 = 13'h031;
    tick();
    sv3 = 1'b0;
    chk("fl_k2", f3, 1'b0);
    tick();
    tick();
    chk("fl_k4_iv", iv3, 1'b1);
    chk("fl_k4_ia", ia3, 13'h030);
    chk("fl_k4", f3, 1'b0);
    tick();
    tick();
    chk("fl_k6", f3, 1'b0);
    tick();
    chk("fl_k7_iv", iv3, 1'b1);
    chk("fl_k7_ia", ia3, 13'h031);
    chk("fl_k7", f3, 1'b1);
    tick();
    chk("fl_k8", f3, 1'b1);
    h3 = 1'b0;
    tick();
    chk("fl_release", f3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
